// File: rtl/env_adsr_pkg.sv
// Shared constants, state encoding and CV clamping helper for the ADSR envelope.
package env_adsr_pkg;

  localparam int unsigned W        = 16;
  localparam int unsigned FRAC     = 8;
  localparam int unsigned ACC_W    = W - 1 + FRAC;
  localparam int          GATE_HI  = 4000;
  localparam int          GATE_LO  = 2000;
  localparam int unsigned TRIG_LEN = 48;
  localparam int unsigned TRIG_W   = $clog2(TRIG_LEN + 1);

  localparam logic [W-1:0]   GATE_OUT_HI = W'((1 << (W - 2)) - 1);
  // Full-scale envelope, expressed in accumulator units (ACC_W+1 bits).
  localparam logic [ACC_W:0] ACC_MAX     = {1'b0, {(W - 1){1'b1}}, {FRAC{1'b0}}};

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} adsr_state_t;

  // Negative CVs clamp to zero; result is zero-extended to compare width.
  function automatic logic [ACC_W:0] clamp_pos(input logic [W-1:0] x);
    return x[W-1] ? '0 : {{(ACC_W + 1 - W){1'b0}}, x};
  endfunction

endpackage

// File: rtl/env_adsr_gate_hyst.sv
// Sample-clock synchroniser with tick generation and a hysteresis gate comparator.
module gate_hyst
  import env_adsr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in,
  output logic                tick,
  output logic                gate,
  output logic                rise,
  output logic                fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_gate;
  logic w_gate_nxt;

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= sample_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign tick = r_sync2 & ~r_sync3;

  // Hysteresis: between the thresholds the previous gate state is held.
  always_comb begin
    w_gate_nxt = r_gate;
    if (sample_in > GATE_HI) begin
      w_gate_nxt = 1'b1;
    end else if (sample_in < GATE_LO) begin
      w_gate_nxt = 1'b0;
    end
  end

  // Gate state advances only on sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate <= 1'b0;
    end else if (tick) begin
      r_gate <= w_gate_nxt;
    end
  end

  assign gate = r_gate;
  assign rise = tick & w_gate_nxt & ~r_gate;
  assign fall = tick & ~w_gate_nxt & r_gate;

endmodule

// File: rtl/env_adsr.sv
// ADSR envelope generator: per-tick FSM over a fractional accumulator with registered outputs.
module env_adsr
  import env_adsr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3
);

  logic w_tick;
  logic w_gate;
  logic w_rise;
  logic w_fall;

  adsr_state_t       r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [TRIG_W-1:0] r_trig;
  logic [W-1:0]      r_out0;
  logic [W-1:0]      r_out1;
  logic [W-1:0]      r_out2;
  logic [W-1:0]      r_out3;

  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_a_step;
  logic [ACC_W:0] w_r_step;
  logic [ACC_W:0] w_sus;
  logic [ACC_W:0] w_sum;
  logic [W-1:0]   w_env;

  gate_hyst u_gate_hyst (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_clk (sample_clk),
    .sample_in  (sample_in0),
    .tick       (w_tick),
    .gate       (w_gate),
    .rise       (w_rise),
    .fall       (w_fall)
  );

  // All arithmetic is one bit wider than the accumulator so nothing can wrap.
  assign w_acc_ext = {1'b0, r_acc};
  assign w_a_step  = clamp_pos(sample_in1) + 1'b1;
  assign w_r_step  = clamp_pos(sample_in2) + 1'b1;
  assign w_sus     = clamp_pos(sample_in3) << FRAC;
  assign w_sum     = w_acc_ext + w_a_step;
  assign w_env     = {1'b0, r_acc[ACC_W-1:FRAC]};

  // Envelope FSM (per tick) and output registers (every clk, so one clk behind state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_trig  <= '0;
      r_out0  <= '0;
      r_out1  <= '0;
      r_out2  <= '0;
      r_out3  <= '0;
    end else begin
      r_out0 <= w_env;
      r_out1 <= w_gate ? GATE_OUT_HI : '0;
      r_out2 <= (r_trig != '0) ? GATE_OUT_HI : '0;
      r_out3 <= -w_env;
      if (w_tick) begin
        if (r_trig != '0) begin
          r_trig <= r_trig - 1'b1;
        end
        // Gate edges override level-driven moves; retrigger keeps the current level.
        if (w_rise) begin
          r_state <= ATTACK;
        end else if (w_fall && (r_state != IDLE)) begin
          r_state <= RELEASE;
        end else begin
          unique case (r_state)
            ATTACK: begin
              if (w_sum >= ACC_MAX) begin
                r_acc   <= ACC_MAX[ACC_W-1:0];
                r_state <= DECAY;
                r_trig  <= TRIG_W'(TRIG_LEN);
              end else begin
                r_acc <= w_sum[ACC_W-1:0];
              end
            end
            DECAY: begin
              if (w_acc_ext <= w_sus + w_r_step) begin
                r_acc   <= w_sus[ACC_W-1:0];
                r_state <= SUSTAIN;
              end else begin
                r_acc <= r_acc - w_r_step[ACC_W-1:0];
              end
            end
            SUSTAIN: r_acc <= w_sus[ACC_W-1:0];
            RELEASE: begin
              if (w_acc_ext <= w_r_step) begin
                r_acc   <= '0;
                r_state <= IDLE;
              end else begin
                r_acc <= r_acc - w_r_step[ACC_W-1:0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign sample_out0 = r_out0;
  assign sample_out1 = r_out1;
  assign sample_out2 = r_out2;
  assign sample_out3 = r_out3;

endmodule

// File: tb/tb_env_adsr.sv
// Directed bench for env_adsr with a behavioural envelope model feeding a scoreboard queue.
module tb_env_adsr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_clk = 1'b0;
  logic signed [15:0] sample_in0 = '0;
  logic signed [15:0] sample_in1 = '0;
  logic signed [15:0] sample_in2 = '0;
  logic signed [15:0] sample_in3 = '0;
  logic signed [15:0] sample_out0;
  logic signed [15:0] sample_out1;
  logic signed [15:0] sample_out2;
  logic signed [15:0] sample_out3;

  env_adsr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_clk  (sample_clk),
    .sample_in0  (sample_in0),
    .sample_in1  (sample_in1),
    .sample_in2  (sample_in2),
    .sample_in3  (sample_in3),
    .sample_out0 (sample_out0),
    .sample_out1 (sample_out1),
    .sample_out2 (sample_out2),
    .sample_out3 (sample_out3)
  );

  always #1 clk = ~clk;

  typedef struct {
    int o0;
    int o1;
    int o2;
    int o3;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err = 0;

  // Reference model state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int     m_state = 0;
  longint m_acc = 0;
  bit     m_gate = 1'b0;
  int     m_trig = 0;
  localparam longint M_MAX = 64'd32767 * 64'd256;
  localparam int HI = 16383;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_acc = 0;
    m_gate = 1'b0;
    m_trig = 0;
  endtask

  task automatic model_tick(input int in0, input int in1, input int in2, input int in3);
    longint a_step, r_step, sus;
    bit g_new, rise, fall;
    exp_t e;
    a_step = longint'((in1 < 0) ? 0 : in1) + 1;
    r_step = longint'((in2 < 0) ? 0 : in2) + 1;
    sus    = longint'((in3 < 0) ? 0 : in3) * 256;
    g_new  = (in0 > 4000) ? 1'b1 : ((in0 < 2000) ? 1'b0 : m_gate);
    rise   = g_new && !m_gate;
    fall   = !g_new && m_gate;
    m_gate = g_new;
    if (m_trig != 0) m_trig--;
    if (rise) m_state = 1;
    else if (fall && m_state != 0) m_state = 4;
    else begin
      case (m_state)
        1: if (m_acc + a_step >= M_MAX) begin
             m_acc = M_MAX; m_state = 2; m_trig = 48;
           end else m_acc = m_acc + a_step;
        2: if (m_acc <= sus + r_step) begin
             m_acc = sus; m_state = 3;
           end else m_acc = m_acc - r_step;
        3: m_acc = sus;
        4: if (m_acc <= r_step) begin
             m_acc = 0; m_state = 0;
           end else m_acc = m_acc - r_step;
        default: ;
      endcase
    end
    e.o0 = int'(m_acc / 256);
    e.o1 = m_gate ? HI : 0;
    e.o2 = (m_trig != 0) ? HI : 0;
    e.o3 = -e.o0;
    sb.push_back(e);
  endtask

  // One sample period: 4 clks, inputs held stable across the tick and the output update.
  task automatic step(input int in0, input int in1, input int in2, input int in3);
    exp_t e;
    sample_in0 = 16'(in0);
    sample_in1 = 16'(in1);
    sample_in2 = 16'(in2);
    sample_in3 = 16'(in3);
    model_tick(in0, in1, in2, in3);
    sample_clk = 1'b1;
    repeat (2) @(negedge clk);
    sample_clk = 1'b0;
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    chk("sb_out0", int'(sample_out0), e.o0);
    chk("sb_out1", int'(sample_out1), e.o1);
    chk("sb_out2", int'(sample_out2), e.o2);
    chk("sb_out3", int'(sample_out3), e.o3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out0"}, int'(sample_out0), 0);
    chk({tag, "_out1"}, int'(sample_out1), 0);
    chk({tag, "_out2"}, int'(sample_out2), 0);
    chk({tag, "_out3"}, int'(sample_out3), 0);
  endtask

  initial begin
    int hyst_in[5];
    int hyst_gate[5];
    int n_rise, n_fall, prev_g, peak_tick, trig_ticks, first_slope, cnt;

    // Power-on reset.
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_reset");

    // Hysteresis sequence.
    hyst_in = '{3000, 4001, 3000, 2001, 1999};
    hyst_gate = '{0, HI, HI, HI, 0};
    n_rise = 0;
    n_fall = 0;
    prev_g = 0;
    for (int i = 0; i < 5; i++) begin
      step(hyst_in[i], 0, 32767, 0);
      chk("hyst_gate", int'(sample_out1), hyst_gate[i]);
      if (prev_g == 0 && int'(sample_out1) != 0) n_rise++;
      if (prev_g != 0 && int'(sample_out1) == 0) n_fall++;
      prev_g = int'(sample_out1);
    end
    chk("hyst_rises", n_rise, 1);
    chk("hyst_falls", n_fall, 1);
    step(0, 0, 32767, 0);

    // Reset in the middle of an attack.
    for (int i = 0; i < 5; i++) step(8000, 32767, 32767, 16384);
    chk("pre_reset_attack", int'(sample_out0), 512);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("mid_reset");
    model_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("mid_reset_rel");
    step(0, 32767, 32767, 16384);

    // Full attack, peak, trigger width, decay to sustain.
    step(8000, 32767, 32767, 16384);
    peak_tick = 0;
    trig_ticks = 0;
    first_slope = -1;
    for (int i = 1; i <= 400; i++) begin
      step(8000, 32767, 32767, 16384);
      if (i == 1) first_slope = int'(sample_out0);
      if (peak_tick == 0 && int'(sample_out0) == 32767) peak_tick = i;
      if (int'(sample_out2) != 0) trig_ticks++;
    end
    chk("attack_slope", first_slope, 128);
    chk("peak_tick", peak_tick, 256);
    chk("trig_ticks", trig_ticks, 48);
    chk("sustain_level", int'(sample_out0), 16384);

    // Sustain tracks the live CV in both directions.
    step(8000, 32767, 32767, 8192);
    chk("sus_snap_down", int'(sample_out0), 8192);
    step(8000, 32767, 32767, 16384);
    chk("sus_snap_up", int'(sample_out0), 16384);

    // Slow release from 16384 down to 10000.
    step(0, 32767, 255, 16384);
    chk("rel_gate_off", int'(sample_out1), 0);
    chk("rel_start", int'(sample_out0), 16384);
    cnt = 0;
    while (int'(sample_out0) != 10000 && cnt < 7000) begin
      step(0, 32767, 255, 16384);
      cnt++;
    end
    chk("rel_ticks_to_10000", cnt, 6384);

    // Retrigger from 10000 with the minimum attack step.
    step(8000, -5, 255, 16384);
    chk("retrig_level", int'(sample_out0), 10000);
    for (int i = 0; i < 600; i++) step(8000, -5, 255, 16384);
    chk("retrig_min_step", int'(sample_out0), 10002);

    // Release all the way to idle.
    step(0, -5, 255, 16384);
    cnt = 0;
    while (int'(sample_out0) != 0 && cnt < 11000) begin
      step(0, -5, 255, 16384);
      cnt++;
    end
    chk("rel_ticks_to_zero", cnt, 10002);
    step(0, -5, 255, 16384);
    chk("idle_out0", int'(sample_out0), 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
